reg_file_sb: RTL

- Parametrised successor to the 8x16 single-write register file.
- Adds configurable width, depth and read-port count, plus a second write port and optional hardwired zero register.
- Adds write-to-read bypass and a per-register pending scoreboard so the pipelined datapath can detect RAW hazards.
- Sits between decode (issue/read) and writeback (two write ports: ALU and load).

---
 rtl/rf_pkg.sv | 19 +
 rtl/rf_scoreboard.sv | 44 ++++
 rtl/reg_file_sb.sv | 88 ++++++++
 3 files changed

// File: rtl/rf_pkg.sv
// Shared defaults, types and helpers for the parametrised register file
// with RAW-hazard scoreboard.
package rf_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 3;

  typedef logic [DEF_DATA_W-1:0] rf_data_t;
  typedef logic [DEF_ADDR_W-1:0] rf_addr_t;

  // Counts set bits; callers zero-extend narrower vectors to 256 bits.
  function automatic int unsigned popcount(input logic [255:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < 256; i++) c += 32'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending bits for RAW hazard detection, plus a registered
// count of how many registers are currently awaiting writeback.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr0_en,
  input  logic [ADDR_W-1:0]     wr0_addr,
  input  logic                  wr1_en,
  input  logic [ADDR_W-1:0]     wr1_addr,
  input  logic                  iss_en,
  input  logic [ADDR_W-1:0]     iss_addr,
  output logic [(1<<ADDR_W)-1:0] pending,
  output logic [ADDR_W:0]       pending_cnt
);

  localparam int NREG = 1 << ADDR_W;
  localparam int CW   = ADDR_W + 1;

  logic [NREG-1:0] pend_n;

  // Clears first, then the issue: a newer producer beats a retiring one.
  always_comb begin
    pend_n = pending;
    if (wr0_en) pend_n[wr0_addr] = 1'b0;
    if (wr1_en) pend_n[wr1_addr] = 1'b0;
    if (iss_en && !(ZERO_REG != 0 && iss_addr == '0)) pend_n[iss_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending     <= '0;
      pending_cnt <= '0;
    end else begin
      pending     <= pend_n;
      pending_cnt <= CW'(popcount(256'(pend_n)));
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// Multi-port register file with two write ports (wr1 has priority),
// optional write-to-read bypass, optional zero register and a pending scoreboard.
module reg_file_sb
  import rf_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr0_en,
  input  logic [ADDR_W-1:0]        wr0_addr,
  input  logic [DATA_W-1:0]        wr0_data,
  input  logic                     wr1_en,
  input  logic [ADDR_W-1:0]        wr1_addr,
  input  logic [DATA_W-1:0]        wr1_data,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_pending,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic [ADDR_W:0]          pending_cnt
);

  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [NREG];
  logic [NREG-1:0]   pending;
  logic              wr0_eff;
  logic              wr1_eff;

  // Writes to the hardwired zero register never land; gating with rst keeps
  // bypass from leaking write data while reset is held.
  assign wr0_eff = rst && wr0_en && !(ZERO_REG != 0 && wr0_addr == '0);
  assign wr1_eff = rst && wr1_en && !(ZERO_REG != 0 && wr1_addr == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREG; r++) regs[r] <= '0;
    end else begin
      if (wr0_eff) regs[wr0_addr] <= wr0_data;
      if (wr1_eff) regs[wr1_addr] <= wr1_data;
    end
  end

  rf_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk         (clk),
    .rst         (rst),
    .wr0_en      (wr0_eff),
    .wr0_addr    (wr0_addr),
    .wr1_en      (wr1_eff),
    .wr1_addr    (wr1_addr),
    .iss_en      (iss_en),
    .iss_addr    (iss_addr),
    .pending     (pending),
    .pending_cnt (pending_cnt)
  );

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] d;
    logic              hit0;
    logic              hit1;
    logic              is_zero;

    assign ra      = rd_addr[i*ADDR_W +: ADDR_W];
    assign hit0    = (BYPASS != 0) && wr0_eff && (wr0_addr == ra);
    assign hit1    = (BYPASS != 0) && wr1_eff && (wr1_addr == ra);
    assign is_zero = (ZERO_REG != 0) && (ra == '0);

    always_comb begin
      d = regs[ra];
      if (hit1)      d = wr1_data;
      else if (hit0) d = wr0_data;
      if (is_zero)   d = '0;
    end

    assign rd_data[i*DATA_W +: DATA_W] = d;
    assign rd_pending[i] = pending[ra] && !hit0 && !hit1 && !is_zero;
  end

endmodule
